// File: rtl/ula_issue_unit.sv
// ula_issue_unit: issue/writeback front-end for the ULA datapath block.
// It accepts one instruction, reads its two source registers from a
// synchronous register file, drives the ULA for one execute cycle, and
// returns the captured result on a response handshake.
//
// Handshakes: a transfer happens on the rising edge where valid && ready.
// Both sides are plain valid/ready. The unit raises instr_ready only in IDLE.
// resp_valid is high only in DONE, and every resp_* output stays stable
// until the consumer raises resp_ready.
module ula_issue_unit #(
    parameter bit IMM_SIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    // instruction side
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    // register file
    output logic [4:0]  rf_addr_a,
    output logic [4:0]  rf_addr_b,
    input  logic [31:0] rf_data_a,
    input  logic [31:0] rf_data_b,
    // ULA drive and capture
    output logic [31:0] data_src,
    output logic [31:0] data_tgtImd,
    output logic [4:0]  shamt,
    output logic [4:0]  opcode_ULA,
    input  logic [31:0] data_ULA,
    input  logic        zero,
    // response side
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_zero,
    output logic        resp_error,
    output logic        resp_divzero,
    // FSM state, exported for observation
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [4:0] OP_BLANK = 5'b00000;
    localparam logic [4:0] OP_DIV   = 5'b00111;

    // state and latched instruction fields
    logic [1:0]  state_q,        state_d;
    logic [4:0]  code_q,         code_d;
    logic        imm_form_q,     imm_form_d;
    logic [4:0]  shamt_f_q,      shamt_f_d;
    logic [15:0] imm16_q,        imm16_d;

    // register-file addresses and ULA operands
    logic [4:0]  rf_addr_a_q,    rf_addr_a_d;
    logic [4:0]  rf_addr_b_q,    rf_addr_b_d;
    logic [31:0] data_src_q,     data_src_d;
    logic [31:0] data_tgt_q,     data_tgt_d;
    logic [4:0]  shamt_q,        shamt_d;

    // response registers
    logic [31:0] resp_data_q,    resp_data_d;
    logic [4:0]  resp_rd_q,      resp_rd_d;
    logic        resp_zero_q,    resp_zero_d;
    logic        resp_error_q,   resp_error_d;
    logic        resp_divzero_q, resp_divzero_d;

    logic        accept;
    logic        in_legal;
    logic [31:0] imm_ext;

    // Legal ULA codes are 0x02-0x0E and 0x10-0x15.
    function automatic logic code_is_legal(input logic [4:0] c);
        logic ok;
        ok = 1'b0;
        if ((c >= 5'h02) && (c <= 5'h0E)) begin
            ok = 1'b1;
        end
        if ((c >= 5'h10) && (c <= 5'h15)) begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    // Handshake qualifiers and the imm16 extension.
    always_comb begin
        accept   = instr_valid && (state_q == ST_IDLE);
        in_legal = code_is_legal(instr[30:26]);
        if (IMM_SIGNED) begin
            imm_ext = {{16{imm16_q[15]}}, imm16_q};
        end else begin
            imm_ext = {16'h0000, imm16_q};
        end
    end

    // Next-state and datapath update for the IDLE/READ/EXEC/DONE sequence.
    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        imm_form_d     = imm_form_q;
        shamt_f_d      = shamt_f_q;
        imm16_d        = imm16_q;
        rf_addr_a_d    = rf_addr_a_q;
        rf_addr_b_d    = rf_addr_b_q;
        data_src_d     = data_src_q;
        data_tgt_d     = data_tgt_q;
        shamt_d        = shamt_q;
        resp_data_d    = resp_data_q;
        resp_rd_d      = resp_rd_q;
        resp_zero_d    = resp_zero_q;
        resp_error_d   = resp_error_q;
        resp_divzero_d = resp_divzero_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    code_d         = instr[30:26];
                    imm_form_d     = instr[31];
                    shamt_f_d      = instr[10:6];
                    imm16_d        = instr[15:0];
                    // immediate form writes rt, register form writes rd
                    resp_rd_d      = instr[31] ? instr[20:16] : instr[15:11];
                    resp_data_d    = 32'h0000_0000;
                    resp_zero_d    = 1'b0;
                    resp_divzero_d = 1'b0;
                    if (in_legal) begin
                        rf_addr_a_d  = instr[25:21];
                        rf_addr_b_d  = instr[20:16];
                        resp_error_d = 1'b0;
                        state_d      = ST_READ;
                    end else begin
                        // illegal code: no register read, no ULA issue
                        resp_error_d = 1'b1;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                data_src_d = rf_data_a;
                data_tgt_d = imm_form_q ? imm_ext : rf_data_b;
                shamt_d    = shamt_f_q;
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                resp_data_d    = data_ULA;
                resp_zero_d    = zero;
                resp_divzero_d = (code_q == OP_DIV) && (data_tgt_q == 32'h0000_0000);
                state_d        = ST_DONE;
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight or pending response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            code_q         <= 5'd0;
            imm_form_q     <= 1'b0;
            shamt_f_q      <= 5'd0;
            imm16_q        <= 16'h0000;
            rf_addr_a_q    <= 5'd0;
            rf_addr_b_q    <= 5'd0;
            data_src_q     <= 32'h0000_0000;
            data_tgt_q     <= 32'h0000_0000;
            shamt_q        <= 5'd0;
            resp_data_q    <= 32'h0000_0000;
            resp_rd_q      <= 5'd0;
            resp_zero_q    <= 1'b0;
            resp_error_q   <= 1'b0;
            resp_divzero_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            imm_form_q     <= imm_form_d;
            shamt_f_q      <= shamt_f_d;
            imm16_q        <= imm16_d;
            rf_addr_a_q    <= rf_addr_a_d;
            rf_addr_b_q    <= rf_addr_b_d;
            data_src_q     <= data_src_d;
            data_tgt_q     <= data_tgt_d;
            shamt_q        <= shamt_d;
            resp_data_q    <= resp_data_d;
            resp_rd_q      <= resp_rd_d;
            resp_zero_q    <= resp_zero_d;
            resp_error_q   <= resp_error_d;
            resp_divzero_q <= resp_divzero_d;
        end
    end

    // Output drive. The read addresses are presented during the accept cycle
    // so the synchronous register file samples them on the accept edge and its
    // data is ready during READ. They are then held from the registered copy.
    // Illegal codes never touch the addresses.
    always_comb begin
        instr_ready  = (state_q == ST_IDLE);
        rf_addr_a    = (accept && in_legal) ? instr[25:21] : rf_addr_a_q;
        rf_addr_b    = (accept && in_legal) ? instr[20:16] : rf_addr_b_q;
        data_src     = data_src_q;
        data_tgtImd  = data_tgt_q;
        shamt        = shamt_q;
        opcode_ULA   = (state_q == ST_EXEC) ? code_q : OP_BLANK;
        resp_valid   = (state_q == ST_DONE);
        resp_data    = resp_data_q;
        resp_rd      = resp_rd_q;
        resp_zero    = resp_zero_q;
        resp_error   = resp_error_q;
        resp_divzero = resp_divzero_q;
        dbg_state    = state_q;
    end

endmodule
